uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Synchronous receive FIFO that sits directly downstream of the UART receiver. It captures each byte presented on the receiver's WRITE/DATA outputs and returns back-pressure through ISFULL, which the receiver samples before it accepts a new start bit. It buffers bytes for the system-side consumer, which drains them with a single-cycle READ strobe. The FIFO also provides occupancy, almost-full and sticky overflow/underflow status.

## Interface

- DATAWIDTH, 8, width of each stored word; matches the receiver data width.
- ADDRWIDTH, 4, log2 of depth; depth = 2**ADDRWIDTH = 16 entries.
- AFULL_LEVEL, 12, ALMOST_FULL asserts when COUNT >= AFULL_LEVEL; legal range 1..depth.

- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  reset, synchronous, active-high.
- WRITE  in  1  write strobe from the receiver; one word per cycle while high.
- WDATA  in  DATAWIDTH  write data; sampled on the edge where WRITE=1.
- ISFULL  out  1  COUNT == depth; goes to the receiver's ISFULL.
- READ  in  1  read strobe from the consumer.
- RDATA  out  DATAWIDTH  registered read data.
- ISEMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AFULL_LEVEL.
- COUNT  out  ADDRWIDTH+1  current occupancy, 0..depth.
- OVERFLOW  out  1  sticky; set when WRITE=1 is seen while ISFULL=1.
- UNDERFLOW  out  1  sticky; set when READ=1 is seen while ISEMPTY=1.
- CLR_ERR  in  1  clears OVERFLOW and UNDERFLOW.

## Operation

- Storage is a DATAWIDTH x depth register array, not reset.
- Pointers: wr_ptr and rd_ptr, each ADDRWIDTH bits wide, wrap modulo depth with no special case at the boundary.
- Accepted write: WRITE=1 and ISFULL=0.
  - mem[wr_ptr] <= WDATA.
  - wr_ptr increments.
- Accepted read: READ=1 and ISEMPTY=0.
  - RDATA <= mem[rd_ptr].
  - rd_ptr increments.
- Occupancy update on each edge:
  - COUNT +1 on an accepted write only.
  - COUNT -1 on an accepted read only.
  - COUNT unchanged when both or neither are accepted.
- Status outputs ISFULL, ISEMPTY and ALMOST_FULL are registered. They are computed from the next value of COUNT, so they are consistent with COUNT in every cycle.
- Acceptance decisions use the registered flag values present in the current cycle.
- Simultaneous write and read:
  - When full: both are accepted. The read takes the oldest word, the write fills the freed slot, and COUNT stays at depth.
  - When empty: only the write is accepted. The read is rejected, UNDERFLOW is set, and RDATA holds its value.
- Rejected write while full: data is discarded, pointers and COUNT are unchanged, and OVERFLOW is set.
- Rejected read while empty: RDATA holds, and UNDERFLOW is set.
- Sticky flags:
  - CLR_ERR=1 clears both flags on the edge.
  - If a new error event occurs in the same cycle as CLR_ERR, the set wins.
- RDATA changes only on an accepted read or on reset.

## Timing

- Reset values, applied on the first edge with RST=1:
  - RDATA=0, COUNT=0, ISEMPTY=1, ISFULL=0, ALMOST_FULL=0, OVERFLOW=0, UNDERFLOW=0.
  - Pointers are 0.
- Reset in the middle of operation flushes all contents logically: the FIFO reads empty after that edge, and reset has priority over WRITE, READ and CLR_ERR.
- Write-to-visible latency: a word written on edge N sets ISEMPTY=0 after edge N. It can be read on edge N+1, with RDATA valid after edge N+1.
- Read latency: 1 cycle. READ sampled on edge N gives RDATA valid after edge N and held until the next accepted read.
- ISFULL rises immediately after the edge that accepts the depth-th word. The receiver therefore sees back-pressure in the next cycle.
- Throughput: one write and one read per cycle, sustained.

## Test plan

- Reset and single word: assert RST for 2 cycles, then write 0xA5 once and read once. Required: ISEMPTY 1→0→1, COUNT 0→1→0, RDATA=0xA5 one cycle after READ.
- Fill and overflow: write 0x00..0x0F (16 words), then write 0xFF.
  - ISFULL=1 after the 16th write, with COUNT=16.
  - ALMOST_FULL=1 from COUNT=12.
  - OVERFLOW=1 after the 17th write.
  - Draining 16 reads returns 0x00..0x0F in order, with no 0xFF.
- Wrap-around: do 10 writes and 10 reads, then 16 writes and 16 reads with an incrementing pattern. Required: order is preserved across the pointer wrap, and COUNT returns to 0.
- Simultaneous read and write:
  - At COUNT=16, hold WRITE=READ=1 for 5 cycles. Required: COUNT stays 16 and the outputs are the oldest words in order.
  - At COUNT=0, assert WRITE=READ=1 with 0x3C. Required: COUNT=1, UNDERFLOW=1, RDATA unchanged.
- Sticky clear: after UNDERFLOW is set, assert CLR_ERR together with a READ on an empty FIFO. Required: UNDERFLOW stays 1. Then CLR_ERR alone gives 0.
- Mid-operation reset: with COUNT=7, assert RST for 1 cycle alongside WRITE. Required: COUNT=0, ISEMPTY=1, RDATA=0, flags 0, and the next read is rejected as underflow.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the system-side consumer.
// Registered read data, registered status flags, sticky overflow/underflow.
module uart_rx_fifo #(
  parameter int DATAWIDTH   = 8,
  parameter int ADDRWIDTH   = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 WRITE,
  input  logic [DATAWIDTH-1:0] WDATA,
  output logic                 ISFULL,
  input  logic                 READ,
  output logic [DATAWIDTH-1:0] RDATA,
  output logic                 ISEMPTY,
  output logic                 ALMOST_FULL,
  output logic [ADDRWIDTH:0]   COUNT,
  output logic                 OVERFLOW,
  output logic                 UNDERFLOW,
  input  logic                 CLR_ERR
);

  localparam logic [ADDRWIDTH:0] DEPTH_C = (ADDRWIDTH+1)'(1) << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0] AFULL_C = (ADDRWIDTH+1)'(AFULL_LEVEL);

  logic [DATAWIDTH-1:0] mem [DEPTH_C];
  logic [ADDRWIDTH-1:0] wr_ptr;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic                 wr_accept;
  logic                 rd_accept;
  logic                 ovf_event;
  logic                 unf_event;
  logic [ADDRWIDTH:0]   count_next;

  // A read on a full FIFO frees a slot, so a concurrent write is also taken.
  always_comb begin
    rd_accept  = READ & ~ISEMPTY;
    wr_accept  = WRITE & (~ISFULL | rd_accept);
    ovf_event  = WRITE & ~wr_accept;
    unf_event  = READ & ISEMPTY;
    count_next = COUNT;
    if (wr_accept && !rd_accept)
      count_next = COUNT + (ADDRWIDTH+1)'(1);
    else if (rd_accept && !wr_accept)
      count_next = COUNT - (ADDRWIDTH+1)'(1);
  end

  always_ff @(posedge CLK) begin
    if (wr_accept)
      mem[wr_ptr] <= WDATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      RDATA       <= '0;
      COUNT       <= '0;
      ISEMPTY     <= 1'b1;
      ISFULL      <= 1'b0;
      ALMOST_FULL <= 1'b0;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      if (wr_accept)
        wr_ptr <= wr_ptr + ADDRWIDTH'(1);
      if (rd_accept) begin
        RDATA  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + ADDRWIDTH'(1);
      end
      COUNT       <= count_next;
      ISEMPTY     <= (count_next == '0);
      ISFULL      <= (count_next == DEPTH_C);
      ALMOST_FULL <= (count_next >= AFULL_C);
      // A new error event in the same cycle as CLR_ERR keeps the flag set.
      OVERFLOW    <= ovf_event | (OVERFLOW & ~CLR_ERR);
      UNDERFLOW   <= unf_event | (UNDERFLOW & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; expected values are hand-derived
// from the intended FIFO behaviour.
module tb_uart_rx_fifo;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WRITE;
  logic [7:0] WDATA;
  logic       ISFULL;
  logic       READ;
  logic [7:0] RDATA;
  logic       ISEMPTY;
  logic       ALMOST_FULL;
  logic [4:0] COUNT;
  logic       OVERFLOW;
  logic       UNDERFLOW;
  logic       CLR_ERR;

  int numChecks = 0;
  int numFails  = 0;

  uart_rx_fifo #(.DATAWIDTH(8), .ADDRWIDTH(4), .AFULL_LEVEL(12)) dut (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .WDATA(WDATA), .ISFULL(ISFULL),
    .READ(READ), .RDATA(RDATA), .ISEMPTY(ISEMPTY), .ALMOST_FULL(ALMOST_FULL),
    .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, lets the edge sample them, then returns to idle.
  task automatic applyStimulus(input logic wr, input logic [7:0] wd, input logic rd,
                               input logic clr, input logic rst);
    WRITE   = wr;
    WDATA   = wd;
    READ    = rd;
    CLR_ERR = clr;
    RST     = rst;
    @(posedge CLK);
    #1;
    WRITE   = 1'b0;
    READ    = 1'b0;
    CLR_ERR = 1'b0;
    RST     = 1'b0;
  endtask

  initial begin
    RST = 1'b1; WRITE = 1'b0; WDATA = '0; READ = 1'b0; CLR_ERR = 1'b0;

    // Reset state
    applyStimulus(0, 8'h00, 0, 0, 1);
    applyStimulus(0, 8'h00, 0, 0, 1);
    checkOutput("rst_rdata", RDATA, 0);
    checkOutput("rst_count", COUNT, 0);
    checkOutput("rst_empty", ISEMPTY, 1);
    checkOutput("rst_full", ISFULL, 0);
    checkOutput("rst_afull", ALMOST_FULL, 0);
    checkOutput("rst_ovf", OVERFLOW, 0);
    checkOutput("rst_unf", UNDERFLOW, 0);

    // Single word
    applyStimulus(1, 8'hA5, 0, 0, 0);
    checkOutput("one_empty", ISEMPTY, 0);
    checkOutput("one_count", COUNT, 1);
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("one_rdata", RDATA, 8'hA5);
    checkOutput("one_empty2", ISEMPTY, 1);
    checkOutput("one_count2", COUNT, 0);

    // Fill, almost-full threshold, overflow
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 8'(i), 0, 0, 0);
      checkOutput($sformatf("fill_count%0d", i), COUNT, i + 1);
      checkOutput($sformatf("fill_afull%0d", i), ALMOST_FULL, (i + 1 >= 12) ? 1 : 0);
      checkOutput($sformatf("fill_full%0d", i), ISFULL, (i == 15) ? 1 : 0);
    end
    applyStimulus(1, 8'hFF, 0, 0, 0);
    checkOutput("ovf_flag", OVERFLOW, 1);
    checkOutput("ovf_count", COUNT, 16);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput($sformatf("drain_rdata%0d", i), RDATA, i);
      checkOutput($sformatf("drain_count%0d", i), COUNT, 15 - i);
    end
    checkOutput("drain_empty", ISEMPTY, 1);
    checkOutput("drain_ovf_sticky", OVERFLOW, 1);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("ovf_clear", OVERFLOW, 0);

    // Wrap-around
    for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'h10 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput($sformatf("wrap1_rdata%0d", i), RDATA, 8'h10 + i);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'(8'h40 + i), 0, 0, 0);
    checkOutput("wrap2_full", ISFULL, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput($sformatf("wrap2_rdata%0d", i), RDATA, 8'h40 + i);
    end
    checkOutput("wrap_count", COUNT, 0);
    checkOutput("wrap_unf", UNDERFLOW, 0);

    // Simultaneous read and write while full
    for (int i = 0; i < 16; i++) applyStimulus(1, 8'(8'h80 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'(8'h90 + i), 1, 0, 0);
      checkOutput($sformatf("rw_full_rdata%0d", i), RDATA, 8'h80 + i);
      checkOutput($sformatf("rw_full_count%0d", i), COUNT, 16);
      checkOutput($sformatf("rw_full_flag%0d", i), ISFULL, 1);
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 8'h00, 1, 0, 0);
      checkOutput($sformatf("rw_drain%0d", i), RDATA, (i < 11) ? (8'h85 + i) : (8'h90 + i - 11));
    end
    checkOutput("rw_drain_empty", ISEMPTY, 1);

    // Simultaneous read and write while empty
    applyStimulus(1, 8'h3C, 1, 0, 0);
    checkOutput("rw_empty_count", COUNT, 1);
    checkOutput("rw_empty_unf", UNDERFLOW, 1);
    checkOutput("rw_empty_rdata", RDATA, 8'h94);
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("rw_empty_read", RDATA, 8'h3C);

    // Sticky clear: a new event beats CLR_ERR
    applyStimulus(0, 8'h00, 1, 1, 0);
    checkOutput("clr_set_wins", UNDERFLOW, 1);
    checkOutput("clr_rdata_hold", RDATA, 8'h3C);
    applyStimulus(0, 8'h00, 0, 1, 0);
    checkOutput("clr_alone", UNDERFLOW, 0);

    // Mid-operation reset with a concurrent write
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("pre_rst_unf", UNDERFLOW, 1);
    for (int i = 0; i < 7; i++) applyStimulus(1, 8'(8'hC0 + i), 0, 0, 0);
    checkOutput("pre_rst_count", COUNT, 7);
    applyStimulus(1, 8'hEE, 0, 0, 1);
    checkOutput("mid_rst_count", COUNT, 0);
    checkOutput("mid_rst_empty", ISEMPTY, 1);
    checkOutput("mid_rst_rdata", RDATA, 0);
    checkOutput("mid_rst_unf", UNDERFLOW, 0);
    checkOutput("mid_rst_ovf", OVERFLOW, 0);
    applyStimulus(0, 8'h00, 1, 0, 0);
    checkOutput("post_rst_unf", UNDERFLOW, 1);
    checkOutput("post_rst_rdata", RDATA, 0);
    checkOutput("post_rst_count", COUNT, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
